// File: rtl/bcd_timer_ctrl.sv
// Programmable up/down BCD timer: loads a sanitised preset, steps a cascaded
// decade chain once per prescaled interval, and holds on the terminal value.
module bcd_timer_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int PS_W     = 10
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic                abort,
  input  logic                pause,
  input  logic                up,
  input  logic [4*DIGITS-1:0] preset,
  output logic [4*DIGITS-1:0] q,
  output logic                tick,
  output logic                busy,
  output logic                done
);

  localparam int QW = 4 * DIGITS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  // Clamp any non-decimal digit to 9 so the chain always holds valid BCD.
  function automatic logic [QW-1:0] sanitise(input logic [QW-1:0] v);
    logic [QW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Full-chain increment/decrement; carry or borrow ripples through every digit
  // in a single evaluation so q only ever changes as a whole.
  function automatic logic [QW-1:0] bcd_step(input logic [QW-1:0] v, input logic dir_up);
    logic [QW-1:0] r;
    logic [3:0]    d;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (c) begin
        if (dir_up) begin
          if (d == 4'd9) begin
            d = 4'd0;
          end else begin
            d = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            d = 4'd9;
          end else begin
            d = d - 4'd1;
            c = 1'b0;
          end
        end
      end
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

  function automatic logic is_terminal(input logic [QW-1:0] v, input logic dir_up);
    logic all_nine;
    logic all_zero;
    all_nine = 1'b1;
    all_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] != 4'd9) all_nine = 1'b0;
      if (v[4*i +: 4] != 4'd0) all_zero = 1'b0;
    end
    return dir_up ? all_nine : all_zero;
  endfunction

  logic [1:0]      state, state_n;
  logic            dir, dir_n;
  logic [PS_W-1:0] ps, ps_n;
  logic [QW-1:0]   q_n;
  logic            tick_n;
  logic [QW-1:0]   load_val;
  logic [QW-1:0]   step_val;

  assign load_val = sanitise(preset);
  assign step_val = bcd_step(q, dir);

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n = state;
    dir_n   = dir;
    ps_n    = ps;
    q_n     = q;
    tick_n  = 1'b0;
    if (abort) begin
      state_n = S_IDLE;
      ps_n    = '0;
    end else if (start) begin
      q_n     = load_val;
      dir_n   = up;
      ps_n    = '0;
      state_n = is_terminal(load_val, up) ? S_DONE : S_RUN;
    end else begin
      case (state)
        S_RUN: begin
          if (pause) begin
            state_n = S_HOLD;
          end else if (ps == PS_LAST) begin
            ps_n   = '0;
            q_n    = step_val;
            tick_n = 1'b1;
            if (is_terminal(step_val, dir)) state_n = S_DONE;
          end else begin
            ps_n = ps + PS_W'(1);
          end
        end
        S_HOLD: begin
          if (!pause) state_n = S_RUN;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= S_IDLE;
      dir   <= 1'b1;
      ps    <= '0;
      q     <= '0;
      tick  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      dir   <= dir_n;
      ps    <= ps_n;
      q     <= q_n;
      tick  <= tick_n;
      busy  <= (state_n == S_RUN) || (state_n == S_HOLD);
      done  <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Directed bench for bcd_timer_ctrl with DIGITS=2, PRESCALE=3.
module tb_bcd_timer_ctrl;

  logic       clk;
  logic       clr;
  logic       start;
  logic       abort;
  logic       pause;
  logic       up;
  logic [7:0] preset;
  logic [7:0] q;
  logic       tick;
  logic       busy;
  logic       done;

  int checks;
  int errors;
  int tick_cnt;

  bcd_timer_ctrl #(.DIGITS(2), .PRESCALE(3), .PS_W(2)) dut (
    .clk(clk), .clr(clr), .start(start), .abort(abort), .pause(pause),
    .up(up), .preset(preset), .q(q), .tick(tick), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n edges, sampling 1 time unit after each and counting tick pulses.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (tick === 1'b1) tick_cnt++;
    end
  endtask

  task automatic check_status(input string tag, input logic [7:0] eq, input logic et,
                              input logic eb, input logic ed);
    check({tag, ".q"}, 32'(q), 32'(eq));
    check({tag, ".tick"}, 32'(tick), 32'(et));
    check({tag, ".busy"}, 32'(busy), 32'(eb));
    check({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  initial begin
    checks = 0; errors = 0; tick_cnt = 0;
    clr = 1'b1; start = 1'b1; abort = 1'b0; pause = 1'b0; up = 1'b1; preset = 8'h55;

    // Reset, with start held high and ignored
    cyc(2);
    check_status("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    clr = 1'b0; start = 1'b0;
    cyc(1);
    check_status("idle", 8'h00, 1'b0, 1'b0, 1'b0);

    // Down count 12 -> 00
    preset = 8'h12; up = 1'b0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    check_status("dn_load", 8'h12, 1'b0, 1'b1, 1'b0);
    tick_cnt = 0;
    cyc(2);
    check("dn_pre_step", 32'(q), 32'h12);
    cyc(1);
    check_status("dn_11", 8'h11, 1'b1, 1'b1, 1'b0);
    cyc(3);
    check("dn_10", 32'(q), 32'h10);
    cyc(3);
    check("dn_09_borrow", 32'(q), 32'h09);
    cyc(26);
    check_status("dn_01", 8'h01, 1'b0, 1'b1, 1'b0);
    cyc(1);
    check_status("dn_00", 8'h00, 1'b1, 1'b0, 1'b1);
    check("dn_ticks", 32'(tick_cnt), 32'd12);
    cyc(4);
    check_status("dn_hold", 8'h00, 1'b0, 1'b0, 1'b1);

    // Up count with carry, then restart mid-run clears the prescaler
    preset = 8'h19; up = 1'b1; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(3);
    check("up_carry_20", 32'(q), 32'h20);
    cyc(2);
    preset = 8'h97; start = 1'b1;
    cyc(1);
    start = 1'b0;
    tick_cnt = 0;
    check_status("up_reload", 8'h97, 1'b0, 1'b1, 1'b0);
    cyc(2);
    check_status("up_ps_cleared", 8'h97, 1'b0, 1'b1, 1'b0);
    cyc(1);
    check_status("up_98", 8'h98, 1'b1, 1'b1, 1'b0);
    cyc(3);
    check_status("up_99", 8'h99, 1'b1, 1'b0, 1'b1);
    cyc(3);
    check("up_ticks", 32'(tick_cnt), 32'd2);
    check("up_q_held", 32'(q), 32'h99);

    // Pause with prescaler preserved (held at 1)
    preset = 8'h05; up = 1'b0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    pause = 1'b1;
    tick_cnt = 0;
    cyc(10);
    check_status("pause_hold", 8'h05, 1'b0, 1'b1, 1'b0);
    check("pause_ticks", 32'(tick_cnt), 32'd0);
    pause = 1'b0;
    cyc(1);
    check_status("resume_edge", 8'h05, 1'b0, 1'b1, 1'b0);
    cyc(1);
    check_status("resume_p1", 8'h05, 1'b0, 1'b1, 1'b0);
    cyc(1);
    check_status("resume_step", 8'h04, 1'b1, 1'b1, 1'b0);

    // Abort at q=07
    preset = 8'h09; up = 1'b0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(6);
    check("abort_pre", 32'(q), 32'h07);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    check_status("abort", 8'h07, 1'b0, 1'b0, 1'b0);
    cyc(5);
    check_status("abort_idle", 8'h07, 1'b0, 1'b0, 1'b0);

    // Preset 00 down is immediately terminal; then restart from DONE
    preset = 8'h00; up = 1'b0; start = 1'b1;
    cyc(1);
    check_status("zero_done", 8'h00, 1'b0, 1'b0, 1'b1);
    preset = 8'h03;
    cyc(1);
    start = 1'b0;
    check_status("restart_done", 8'h03, 1'b0, 1'b1, 1'b0);
    cyc(3);
    check_status("restart_step", 8'h02, 1'b1, 1'b1, 1'b0);

    // clr mid-run
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    check_status("clr_mid", 8'h00, 1'b0, 1'b0, 1'b0);

    // Sanitised preset AF up -> 99, terminal at once
    preset = 8'hAF; up = 1'b1; start = 1'b1;
    cyc(1);
    start = 1'b0;
    check_status("sanitise", 8'h99, 1'b0, 1'b0, 1'b1);

    // start and abort together -> abort wins
    preset = 8'h50; up = 1'b1; start = 1'b1; abort = 1'b1;
    cyc(1);
    start = 1'b0; abort = 1'b0;
    check_status("abort_wins", 8'h99, 1'b0, 1'b0, 1'b0);
    cyc(4);
    check_status("abort_wins_idle", 8'h99, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
